// File: rtl/editable_text_buffer_pkg.sv
// Shared definitions for the editable text buffer: terminator code, edit command
// encoding and engine state encoding.
package editable_text_buffer_pkg;

    localparam int NUL = 0;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LEFT,
        CMD_RIGHT,
        CMD_BACKSPACE,
        CMD_INSERT
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ITER_READ,
        ST_ITER_OUT
    } state_e;

endpackage

// File: rtl/editable_text_buffer_edit_command_latch.sv
// Captures one keyboard edit command, resolves simultaneous requests by priority and
// holds it until the engine accepts it.
module editable_text_buffer_edit_command_latch
    import editable_text_buffer_pkg::*;
#(
    parameter int SYMBOL_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_left,
    input  logic                    i_right,
    input  logic                    i_backspace,
    input  logic [SYMBOL_WIDTH-1:0] i_symbol,
    input  logic                    i_busy,
    input  logic                    i_accept,
    output logic                    o_pending,
    output cmd_e                    o_cmd,
    output logic [SYMBOL_WIDTH-1:0] o_symbol
);

    cmd_e                    w_cmd;
    logic                    r_pending;
    cmd_e                    r_cmd;
    logic [SYMBOL_WIDTH-1:0] r_symbol;

    always_comb begin
        w_cmd = CMD_NONE;
        if (i_backspace)
            w_cmd = CMD_BACKSPACE;
        else if (i_left)
            w_cmd = CMD_LEFT;
        else if (i_right)
            w_cmd = CMD_RIGHT;
        else if (i_symbol != '0)
            w_cmd = CMD_INSERT;
    end

    // Anything presented while a command is held or being shifted in is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_cmd     <= CMD_NONE;
            r_symbol  <= '0;
        end else if (r_pending) begin
            if (i_accept)
                r_pending <= 1'b0;
        end else if (!i_busy && (w_cmd != CMD_NONE)) begin
            r_pending <= 1'b1;
            r_cmd     <= w_cmd;
            r_symbol  <= i_symbol;
        end
    end

    assign o_pending = r_pending;
    assign o_cmd     = r_cmd;
    assign o_symbol  = r_symbol;

endmodule

// File: rtl/editable_text_buffer.sv
// Single-line text store: applies latched edit commands to a symbol memory with a
// cursor and visible window, and streams the full text or the window on request.
module editable_text_buffer
    import editable_text_buffer_pkg::*;
#(
    parameter int SYMBOL_WIDTH  = 7,
    parameter int SYMBOLS_COUNT = 127,
    parameter int VISIBLE_COUNT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    left,
    input  logic                    right,
    input  logic                    backspace,
    input  logic [SYMBOL_WIDTH-1:0] symbol,
    output logic                    input_ready,
    input  logic                    full_iter_start,
    input  logic                    visible_iter_start,
    input  logic                    iter_en,
    output logic [SYMBOL_WIDTH-1:0] iter_out,
    output logic                    iter_out_valid,
    output logic                    cursor_left,
    output logic                    cursor_right
);

    localparam int PW = $clog2(SYMBOLS_COUNT + 1);
    typedef logic [PW-1:0] pos_t;

    // One spare slot so every position 0..SYMBOLS_COUNT is addressable.
    logic [SYMBOL_WIDTH-1:0] r_mem [SYMBOLS_COUNT+1];

    state_e                  r_state;
    state_e                  w_state_next;
    pos_t                    r_len;
    pos_t                    r_cur;
    pos_t                    r_first;
    pos_t                    r_idx;
    pos_t                    r_pos;
    pos_t                    r_end;
    logic                    r_start_pend;
    logic                    r_start_full;
    logic [SYMBOL_WIDTH-1:0] r_iter_out;
    logic                    r_iter_valid;
    logic                    r_cursor_left;
    logic                    r_cursor_right;

    logic                    w_pending;
    cmd_e                    w_cmd;
    logic [SYMBOL_WIDTH-1:0] w_symbol;
    logic                    w_accept;
    logic                    w_iterating;
    logic                    w_start_in;
    logic                    w_start_go;
    logic                    w_start_full;
    logic                    w_restart;
    logic                    w_ins_ok;
    logic                    w_bs_ok;
    logic                    w_shift_ins;
    logic                    w_shift_done;
    logic                    w_at_end;
    pos_t                    w_load_pos;
    pos_t                    w_start_pos;
    pos_t                    w_start_end;

    function automatic pos_t f_first(input pos_t c, input pos_t f);
        int ci;
        int fi;
        ci = int'(c);
        fi = int'(f);
        if (ci < fi)
            fi = ci;
        else if (ci > fi + VISIBLE_COUNT - 1)
            fi = ci - VISIBLE_COUNT + 1;
        return pos_t'(fi);
    endfunction

    function automatic pos_t f_vis_end(input pos_t f, input pos_t l);
        int e;
        e = int'(f) + VISIBLE_COUNT;
        if (e > int'(l))
            e = int'(l);
        return pos_t'(e);
    endfunction

    editable_text_buffer_edit_command_latch #(
        .SYMBOL_WIDTH(SYMBOL_WIDTH)
    ) u_cmd_latch (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_left     (left),
        .i_right    (right),
        .i_backspace(backspace),
        .i_symbol   (symbol),
        .i_busy     (r_state == ST_SHIFT),
        .i_accept   (w_accept),
        .o_pending  (w_pending),
        .o_cmd      (w_cmd),
        .o_symbol   (w_symbol)
    );

    assign w_iterating  = (r_state == ST_ITER_READ) || (r_state == ST_ITER_OUT);
    assign w_accept     = (r_state == ST_IDLE) && w_pending;
    assign w_start_in   = full_iter_start || visible_iter_start;
    assign w_start_go   = (r_state == ST_IDLE) && !w_pending && (w_start_in || r_start_pend);
    assign w_start_full = w_start_in ? full_iter_start : r_start_full;
    assign w_restart    = w_iterating && w_start_in;
    assign w_start_pos  = w_start_full ? '0 : r_first;
    assign w_start_end  = w_start_full ? r_len : f_vis_end(r_first, r_len);
    assign w_ins_ok     = int'(r_len) < SYMBOLS_COUNT;
    assign w_bs_ok      = (r_cur != '0);
    assign w_shift_ins  = (w_cmd == CMD_INSERT);
    assign w_shift_done = w_shift_ins ? (r_idx == r_cur) : (r_idx == r_len - 1'b1);
    assign w_load_pos   = (r_state == ST_ITER_OUT) ? r_pos + 1'b1 : r_pos;
    assign w_at_end     = (r_pos == r_end);
    assign input_ready  = !w_pending && (r_state == ST_IDLE) && !r_start_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if ((w_cmd == CMD_INSERT && w_ins_ok) || (w_cmd == CMD_BACKSPACE && w_bs_ok))
                        w_state_next = ST_SHIFT;
                end else if (w_start_go) begin
                    w_state_next = ST_ITER_READ;
                end
            end
            ST_SHIFT: begin
                if (w_shift_done)
                    w_state_next = ST_IDLE;
            end
            ST_ITER_READ: begin
                w_state_next = w_restart ? ST_ITER_READ : ST_ITER_OUT;
            end
            ST_ITER_OUT: begin
                if (w_restart)
                    w_state_next = ST_ITER_READ;
                else if (iter_en && w_at_end)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len          <= '0;
            r_cur          <= '0;
            r_first        <= '0;
            r_idx          <= '0;
            r_pos          <= '0;
            r_end          <= '0;
            r_start_pend   <= 1'b0;
            r_start_full   <= 1'b0;
            r_iter_out     <= '0;
            r_iter_valid   <= 1'b0;
            r_cursor_left  <= 1'b0;
            r_cursor_right <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        unique case (w_cmd)
                            CMD_LEFT: begin
                                if (w_bs_ok) begin
                                    r_cur   <= r_cur - 1'b1;
                                    r_first <= f_first(r_cur - 1'b1, r_first);
                                end
                            end
                            CMD_RIGHT: begin
                                if (r_cur != r_len) begin
                                    r_cur   <= r_cur + 1'b1;
                                    r_first <= f_first(r_cur + 1'b1, r_first);
                                end
                            end
                            CMD_BACKSPACE: r_idx <= r_cur - 1'b1;
                            CMD_INSERT:    r_idx <= r_len;
                            default: ;
                        endcase
                    end else if (w_start_go) begin
                        r_pos <= w_start_pos;
                        r_end <= w_start_end;
                    end
                end
                // Insert walks r_idx down from len to cur; backspace walks it up to len-1.
                ST_SHIFT: begin
                    if (w_shift_done) begin
                        if (w_shift_ins) begin
                            r_len   <= r_len + 1'b1;
                            r_cur   <= r_cur + 1'b1;
                            r_first <= f_first(r_cur + 1'b1, r_first);
                        end else begin
                            r_len   <= r_len - 1'b1;
                            r_cur   <= r_cur - 1'b1;
                            r_first <= f_first(r_cur - 1'b1, r_first);
                        end
                    end else begin
                        r_idx <= w_shift_ins ? r_idx - 1'b1 : r_idx + 1'b1;
                    end
                end
                ST_ITER_READ, ST_ITER_OUT: begin
                    if (w_restart) begin
                        r_pos        <= w_start_pos;
                        r_end        <= w_start_end;
                        r_iter_valid <= 1'b0;
                    end else if (r_state == ST_ITER_READ || iter_en) begin
                        if (r_state == ST_ITER_OUT && w_at_end) begin
                            r_iter_valid <= 1'b0;
                        end else begin
                            r_pos          <= w_load_pos;
                            r_iter_out     <= (w_load_pos == r_end) ? SYMBOL_WIDTH'(NUL)
                                                                    : r_mem[w_load_pos];
                            r_cursor_left  <= (w_load_pos == r_cur);
                            r_cursor_right <= w_bs_ok && (w_load_pos == r_cur - 1'b1);
                            r_iter_valid   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (w_start_go) begin
                r_start_pend <= 1'b0;
            end else if (w_start_in && !w_iterating) begin
                r_start_pend <= 1'b1;
                r_start_full <= full_iter_start;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_SHIFT) begin
            if (w_shift_ins) begin
                if (w_shift_done)
                    r_mem[r_cur] <= w_symbol;
                else
                    r_mem[r_idx] <= r_mem[r_idx - 1'b1];
            end else if (!w_shift_done) begin
                r_mem[r_idx] <= r_mem[r_idx + 1'b1];
            end
        end
    end

    assign iter_out       = r_iter_out;
    assign iter_out_valid = r_iter_valid;
    assign cursor_left    = r_cursor_left;
    assign cursor_right   = r_cursor_right;

endmodule

// File: tb/tb_editable_text_buffer.sv
// Bench for editable_text_buffer: directed scenarios then randomized edits, each
// iteration compared against a queue-based model of the text, cursor and window.
module tb_editable_text_buffer;

    localparam int SW = 7;
    localparam int SC = 24;
    localparam int VC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          left = 1'b0;
    logic          right = 1'b0;
    logic          backspace = 1'b0;
    logic [SW-1:0] symbol = '0;
    logic          full_iter_start = 1'b0;
    logic          visible_iter_start = 1'b0;
    logic          iter_en = 1'b0;
    logic          input_ready;
    logic [SW-1:0] iter_out;
    logic          iter_out_valid;
    logic          cursor_left;
    logic          cursor_right;

    int n_checks = 0;
    int n_errors = 0;

    logic [SW-1:0] q[$];
    int m_cur = 0;
    int m_first = 0;

    editable_text_buffer #(
        .SYMBOL_WIDTH (SW),
        .SYMBOLS_COUNT(SC),
        .VISIBLE_COUNT(VC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .left              (left),
        .right             (right),
        .backspace         (backspace),
        .symbol            (symbol),
        .input_ready       (input_ready),
        .full_iter_start   (full_iter_start),
        .visible_iter_start(visible_iter_start),
        .iter_en           (iter_en),
        .iter_out          (iter_out),
        .iter_out_valid    (iter_out_valid),
        .cursor_left       (cursor_left),
        .cursor_right      (cursor_right)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cur = 0;
        m_first = 0;
    endtask

    task automatic model_apply(input logic l, input logic r, input logic b, input logic [SW-1:0] s);
        if (b) begin
            if (m_cur > 0) begin
                q.delete(m_cur - 1);
                m_cur--;
            end
        end else if (l) begin
            if (m_cur > 0) m_cur--;
        end else if (r) begin
            if (m_cur < q.size()) m_cur++;
        end else if (s != '0) begin
            if (q.size() < SC) begin
                q.insert(m_cur, s);
                m_cur++;
            end
        end
        if (m_cur < m_first) m_first = m_cur;
        else if (m_cur > m_first + VC - 1) m_first = m_cur - VC + 1;
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (input_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", 32'(input_ready), 32'd1);
    endtask

    task automatic send_cmd(input logic l, input logic r, input logic b, input logic [SW-1:0] s);
        wait_ready();
        left = l;
        right = r;
        backspace = b;
        symbol = s;
        @(negedge clk);
        left = 1'b0;
        right = 1'b0;
        backspace = 1'b0;
        symbol = '0;
        chk("ready_fall", 32'(input_ready), 32'd0);
        model_apply(l, r, b, s);
    endtask

    task automatic ins_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] ch;
            ch = s[i];
            send_cmd(1'b0, 1'b0, 1'b0, ch[SW-1:0]);
        end
    endtask

    // mode: 0 full, 1 visible, 2 both inputs high (full expected)
    task automatic run_iter(input int mode, input bit pulse, input bit lat_chk, input int hold,
                            input bit stalls);
        int lo;
        int hi;
        int waited;
        logic [SW-1:0] es;
        if (lat_chk) wait_ready();
        if (mode == 1) begin
            lo = m_first;
            hi = (m_first + VC < q.size()) ? m_first + VC : q.size();
        end else begin
            lo = 0;
            hi = q.size();
        end
        if (pulse) begin
            full_iter_start = (mode != 1);
            visible_iter_start = (mode != 0);
            @(negedge clk);
            full_iter_start = 1'b0;
            visible_iter_start = 1'b0;
        end
        waited = 0;
        while (iter_out_valid !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        chk("iter_valid_wait", 32'(iter_out_valid), 32'd1);
        if (lat_chk) chk("iter_latency", 32'(waited <= 1), 32'd1);
        if (iter_out_valid === 1'b1) begin
            for (int p = lo; p <= hi; p++) begin
                int ns;
                es = (p < hi) ? q[p] : '0;
                ns = (p == lo) ? hold : (stalls ? int'($urandom_range(0, 2)) : 0);
                for (int s = 0; s <= ns; s++) begin
                    chk("iter_valid", 32'(iter_out_valid), 32'd1);
                    chk("iter_out", 32'(iter_out), 32'(es));
                    chk("cursor_left", 32'(cursor_left), 32'(p == m_cur));
                    chk("cursor_right", 32'(cursor_right), 32'(p == m_cur - 1));
                    iter_en = (s == ns);
                    @(negedge clk);
                end
            end
            iter_en = 1'b0;
            chk("iter_end", 32'(iter_out_valid), 32'd0);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", 32'(input_ready), 32'd1);
        chk("rst_valid", 32'(iter_out_valid), 32'd0);
        chk("rst_iter_out", 32'(iter_out), 32'd0);
        chk("rst_cursor_left", 32'(cursor_left), 32'd0);
        chk("rst_cursor_right", 32'(cursor_right), 32'd0);
    endtask

    initial begin
        model_reset();
        #3;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        run_iter(0, 1'b1, 1'b1, 0, 1'b0);

        send_cmd(1'b1, 1'b0, 1'b0, '0);
        send_cmd(1'b0, 1'b1, 1'b0, '0);
        send_cmd(1'b0, 1'b0, 1'b1, '0);
        run_iter(0, 1'b1, 1'b1, 0, 1'b0);

        ins_str("a");
        run_iter(0, 1'b1, 1'b1, 0, 1'b0);

        ins_str("bcd");
        run_iter(0, 1'b1, 1'b1, 4, 1'b0);
        run_iter(0, 1'b1, 1'b1, 0, 1'b0);

        send_cmd(1'b0, 1'b0, 1'b1, '0);
        run_iter(0, 1'b1, 1'b0, 0, 1'b0);

        send_cmd(1'b1, 1'b0, 1'b0, '0);
        run_iter(0, 1'b1, 1'b1, 0, 1'b0);
        ins_str("f");
        run_iter(0, 1'b1, 1'b1, 0, 1'b0);
        send_cmd(1'b0, 1'b1, 1'b0, '0);
        run_iter(0, 1'b1, 1'b1, 0, 1'b0);

        for (int i = 0; i < SC + 1; i++)
            send_cmd(1'b0, 1'b0, 1'b0, SW'($urandom_range(1, 127)));
        run_iter(0, 1'b1, 1'b1, 0, 1'b0);
        run_iter(1, 1'b1, 1'b1, 0, 1'b0);
        chk("model_saturated", 32'(q.size()), 32'(SC));

        repeat (20) send_cmd(1'b1, 1'b0, 1'b0, '0);
        wait_ready();
        backspace = 1'b1;
        @(negedge clk);
        backspace = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_shift_busy", 32'(input_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_iter(0, 1'b1, 1'b1, 0, 1'b0);

        ins_str("abcdefg");
        run_iter(1, 1'b1, 1'b1, 0, 1'b0);
        run_iter(2, 1'b1, 1'b1, 0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            logic l;
            logic r;
            logic b;
            logic [SW-1:0] s;
            b = ($urandom_range(0, 5) == 0);
            l = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 2) != 0) ? SW'($urandom_range(1, 127)) : '0;
            if (!b && !l && !r && s == '0) r = 1'b1;
            send_cmd(l, r, b, s);
            if (i % 5 == 4) run_iter(int'($urandom_range(0, 2)), 1'b1, 1'b0, 0, 1'b1);
        end
        run_iter(1, 1'b1, 1'b1, 0, 1'b1);
        run_iter(0, 1'b1, 1'b1, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
